ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter: CLK_DIV, default 50, clk cycles per ps2_clk half-period (legal range 2..1023).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: tx_data  input  8  byte to send (scan code or command response).
REQ-005 SHALL have port: tx_valid  input  1  tx_data valid; transfer occurs when tx_valid && ready.
REQ-006 SHALL have port: ready  output  1  block idle and not inhibited; can accept a byte.
REQ-007 SHALL have port: inhibit  input  1  host holding line clock low; synchronous to clk.
REQ-008 SHALL have port: ps2_clk  output  1  device-driven PS/2 clock, idle high.
REQ-009 SHALL have port: ps2_data  output  1  device-driven PS/2 data, idle high.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when a frame completes including gap.

Function
REQ-011 SHALL send 11-bit frame: start 0, data bits 0..7 LSB first, odd parity (parity = ~^tx_data), stop 1.
REQ-012 SHALL latch tx_data into a frame shift register in the accept cycle; later tx_data changes ignored.
REQ-013 SHALL drive ready = (state == IDLE) && !inhibit, combinationally.
REQ-014 SHALL use states IDLE, HIGH, LOW, GAP, HOLD.
REQ-015 IDLE -> HIGH on accept; bit counter = 0; ps2_data takes start bit in the cycle after accept.
REQ-016 HIGH: ps2_clk = 1 for CLK_DIV cycles; ps2_data = current bit, stable whole HIGH+LOW of that bit; then -> LOW.
REQ-017 LOW: ps2_clk = 0 for CLK_DIV cycles; then bit counter < 10 -> HIGH with next bit; counter == 10 -> GAP.
REQ-018 GAP: ps2_clk = 1, ps2_data = 1 for CLK_DIV cycles; then done = 1 for one cycle and -> IDLE.
REQ-019 Frame length SHALL be exactly 23*CLK_DIV cycles from cycle after accept to done pulse inclusive of gap.
REQ-020 inhibit in HIGH/LOW with bit counter < 10 SHALL abort: next cycle ps2_clk = 1, ps2_data = 1, -> HOLD; byte kept.
REQ-021 inhibit during bit 10 (stop) HIGH/LOW or GAP SHALL be ignored; frame completes normally.
REQ-022 HOLD: lines released high; on inhibit low, wait CLK_DIV cycles then -> HIGH restarting at start bit with same byte.
REQ-023 inhibit high in IDLE SHALL force ready = 0; tx_valid ignored; no frame starts.
REQ-024 done SHALL NOT pulse for aborted attempts; only once per accepted byte.
REQ-025 Divider counter SHALL reset to 0 on every state change; no drift between bits.

Reset
REQ-026 reset low SHALL asynchronously force state = IDLE, ps2_clk = 1, ps2_data = 1, done = 0, counters = 0, frame register = all ones.
REQ-027 reset mid-frame SHALL discard the byte; no done pulse; ready valid the first cycle after reset deasserts (if !inhibit).

Structure
REQ-028 Package ps2_pkg SHALL hold state enum, FRAME_BITS = 11, parity helper function; shared with the receiver.
REQ-029 Sub-module ps2_clk_div SHALL generate the half-period tick (count, clear-on-state-change, tick at CLK_DIV-1).
REQ-030 Outputs ps2_clk, ps2_data, done SHALL be registered.

Verification (CLK_DIV = 4)
REQ-031 Send 0x1C -> data bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1; each bit on falling edge; done at 92 cycles after accept.
REQ-032 Send 0xF0 then 0x1C back-to-back, tx_valid held -> second accept cycle after first done; parities 1 then 0; feed into receiver, it reports 1C as break.
REQ-033 Send 0x00 -> parity 1; frame 0,00000000,1,1.
REQ-034 Assert inhibit after 3rd falling edge -> lines high next cycle, no done; release -> after 4 cycles full frame restarts from start bit, one done total.
REQ-035 Assert inhibit during stop bit -> frame completes, done pulses; inhibit held -> ready = 0.
REQ-036 Assert reset at bit 5 -> ps2_clk = 1, ps2_data = 1 immediately; no done; after release ready = 1 next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions for the device-side transmitter and the receiver.
//   ps2_state_e  : transmitter FSM states
//   FRAME_BITS   : bits per PS/2 frame (start, 8 data, parity, stop)
//   odd_parity() : parity bit that makes the 9-bit data+parity word odd
//   build_frame(): frame image, bit 0 is the first bit on the wire
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        GAP,
        HOLD
    } ps2_state_e;

    localparam int FRAME_BITS = 11;
    localparam int BIT_CNT_W  = 4;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_clk_div.sv
// ---------------------------------------------------------------------------
// ps2_clk_div
// Half-period timer for the PS/2 transmitter. Counts clk cycles from 0 and
// raises tick while the count equals CLK_DIV-1. A clear restarts the count,
// so every state begins a full half-period with no carried-over phase.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   clear : restart count at 0 on the next edge
//   tick  : last cycle of the current half-period
// ---------------------------------------------------------------------------
module ps2_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = 10;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx
// Device-side PS/2 frame transmitter: sends one byte as an 11-bit frame
// (start 0, data LSB first, odd parity, stop 1) followed by one idle gap.
// A host inhibit before the stop bit aborts the attempt; the byte is kept
// and the whole frame is resent once the host releases the line.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   tx_data  : byte to send, captured when tx_valid && ready
//   tx_valid : tx_data valid
//   ready    : idle and not inhibited
//   inhibit  : host holding the clock line low (synchronous to clk)
//   ps2_clk  : PS/2 clock, idle high (registered)
//   ps2_data : PS/2 data, idle high (registered)
//   done     : one-cycle pulse after the gap of a completed frame
//
//   state | meaning
//   IDLE  | lines released, waiting for a byte
//   HIGH  | ps2_clk high half of the current bit
//   LOW   | ps2_clk low half of the current bit
//   GAP   | lines released for one half-period after the stop bit
//   HOLD  | attempt aborted by inhibit, waiting to resend
// ---------------------------------------------------------------------------
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       ready,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    ps2_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [7:0]              byte_q, byte_d;
    logic                    ps2_clk_d, ps2_data_d, done_d;
    logic                    tick, div_clear, accept, abortable;

    assign ready     = (state_q == IDLE) && !inhibit;
    assign accept    = tx_valid && ready;
    // Once the stop bit is on the wire the host can no longer abort.
    assign abortable = (bit_cnt_q < LAST_BIT);
    // Holding the count at 0 while inhibited makes the resend delay start
    // at the release of inhibit.
    assign div_clear = (state_d != state_q) || ((state_q == HOLD) && inhibit);

    ps2_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        byte_d    = byte_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = HIGH;
                    bit_cnt_d = '0;
                    byte_d    = tx_data;
                    frame_d   = build_frame(tx_data);
                end
            end
            HIGH: begin
                if (inhibit && abortable) begin
                    state_d = HOLD;
                end else if (tick) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (inhibit && abortable) begin
                    state_d = HOLD;
                end else if (tick) begin
                    if (abortable) begin
                        state_d   = HIGH;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            HOLD: begin
                if (!inhibit && tick) begin
                    state_d   = HIGH;
                    bit_cnt_d = '0;
                    frame_d   = build_frame(byte_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered lines
        // change on the same edge as the state register.
        ps2_clk_d  = (state_d != LOW);
        ps2_data_d = ((state_d == HIGH) || (state_d == LOW)) ? frame_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '1;
            byte_q    <= '0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            byte_q    <= byte_d;
            ps2_clk   <= ps2_clk_d;
            ps2_data  <= ps2_data_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx
// Directed bench for ps2_tx with CLK_DIV = 4. Inputs are driven and outputs
// sampled on the falling edge of clk. Bits are captured at each ps2_clk
// high-to-low transition. Timing reference: the accept edge is edge 0; a
// full frame puts done high after edge 92 (23 * 4).
// ---------------------------------------------------------------------------
module tb_ps2_tx;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       inhibit = 1'b0;
   logic       ready, ps2_clk, ps2_data, done;

   int   n_pass = 0;
   int   n_total = 0;
   logic prev_clk = 1'b1;
   logic fell = 1'b0;

   ps2_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .ready    (ready),
      .inhibit  (inhibit),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      fell     = prev_clk && !ps2_clk;
      prev_clk = ps2_clk;
   endtask

   // Runs ncyc cycles after an accept (or restart) edge and records the
   // wire bits, the done pulses and the sampled lines in the first cycle.
   task automatic capture(input int ncyc, input logic drop_valid,
                          input logic [7:0] d_after,
                          output logic [10:0] bits, output int nfall,
                          output int done_at, output int ndone,
                          output logic clk0, output logic data0,
                          output logic rdy_done);
      bits = '1; nfall = 0; done_at = -1; ndone = 0;
      clk0 = 1'b0; data0 = 1'b0; rdy_done = 1'b0;
      for (int i = 1; i <= ncyc; i++) begin
         step();
         if (i == 1) begin
            clk0  = ps2_clk;
            data0 = ps2_data;
            if (drop_valid) tx_valid = 1'b0;
            tx_data = d_after;
         end
         if (fell) begin
            if (nfall < 11) bits[nfall[3:0]] = ps2_data;
            nfall++;
         end
         if (done) begin
            ndone++;
            if (done_at < 0) begin
               done_at  = i - 1;
               rdy_done = ready;
            end
         end
      end
   endtask

   logic [10:0] bits, bits2;
   int          nfall, done_at, ndone, nf, dn, cyc, done_cyc;
   logic        clk0, data0, rdy_done, rdy_d, quiet;
   logic [7:0]  rx1, rx2;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_lines", 64'({ps2_clk, ps2_data, done}), 64'(3'b110));
      check("reset_ready", 64'(ready), 64'(1'b1));
      reset = 1'b1;
      step();

      tx_data = 8'h1C; tx_valid = 1'b1;
      check("1c_ready_at_offer", 64'(ready), 64'(1'b1));
      capture(100, 1'b1, 8'hAA, bits, nfall, done_at, ndone, clk0, data0, rdy_done);
      check("1c_start_cycle", 64'({clk0, data0}), 64'(2'b10));
      check("1c_bits", 64'(bits), 64'({1'b1, 1'b0, 8'h1C, 1'b0}));
      check("1c_nfall", 64'(nfall), 64'(11));
      check("1c_done_edge", 64'(done_at), 64'(92));
      check("1c_ndone", 64'(ndone), 64'(1));

      tx_data = 8'hF0; tx_valid = 1'b1;
      capture(93, 1'b0, 8'h1C, bits, nfall, done_at, ndone, clk0, data0, rdy_done);
      check("f0_bits", 64'(bits), 64'({1'b1, 1'b1, 8'hF0, 1'b0}));
      check("f0_done_edge", 64'(done_at), 64'(92));
      check("f0_ready_at_done", 64'(rdy_done), 64'(1'b1));
      capture(100, 1'b1, 8'h55, bits2, nfall, done_at, ndone, clk0, data0, rdy_done);
      check("b2b_start_next_cycle", 64'({clk0, data0}), 64'(2'b10));
      check("b2b_bits", 64'(bits2), 64'({1'b1, 1'b0, 8'h1C, 1'b0}));
      check("b2b_done_edge", 64'(done_at), 64'(92));
      check("b2b_ndone", 64'(ndone), 64'(1));
      rx1 = bits[8:1];
      rx2 = bits2[8:1];
      check("rx_parity_odd", 64'({^bits[9:1], ^bits2[9:1]}), 64'(2'b11));
      check("rx_break_code", 64'({(rx1 == 8'hF0), rx2}), 64'({1'b1, 8'h1C}));

      tx_data = 8'h1C; tx_valid = 1'b1;
      nf = 0; dn = 0;
      for (int i = 0; i < 40 && nf < 3; i++) begin
         step();
         if (i == 0) tx_valid = 1'b0;
         if (fell) nf++;
         if (done) dn++;
      end
      check("inh_third_fall", 64'(nf), 64'(3));
      inhibit = 1'b1;
      step();
      check("inh_lines_released", 64'({ps2_clk, ps2_data, ready}), 64'(3'b110));
      for (int i = 0; i < 6; i++) begin
         step();
         if (done) dn++;
      end
      check("inh_no_done", 64'(dn), 64'(0));
      inhibit = 1'b0;
      capture(110, 1'b0, 8'h1C, bits, nfall, done_at, ndone, clk0, data0, rdy_done);
      check("inh_lines_before_restart", 64'({clk0, data0}), 64'(2'b11));
      check("inh_restart_bits", 64'(bits), 64'({1'b1, 1'b0, 8'h1C, 1'b0}));
      check("inh_restart_nfall", 64'(nfall), 64'(11));
      check("inh_restart_done_at", 64'(done_at), 64'(95));
      check("inh_one_done", 64'(ndone), 64'(1));

      tx_data = 8'h00; tx_valid = 1'b1;
      check("00_ready_at_offer", 64'(ready), 64'(1'b1));
      nf = 0; cyc = 0; bits = '1;
      while (nf < 11 && cyc < 120) begin
         step();
         cyc++;
         if (cyc == 1) tx_valid = 1'b0;
         if (fell) begin
            bits[nf[3:0]] = ps2_data;
            nf++;
         end
      end
      check("00_nfall", 64'(nf), 64'(11));
      inhibit = 1'b1;
      dn = 0; done_cyc = -1; rdy_d = 1'b1;
      while (dn == 0 && cyc < 140) begin
         step();
         cyc++;
         if (done) begin
            dn++;
            done_cyc = cyc - 1;
            rdy_d    = ready;
         end
      end
      check("00_bits", 64'(bits), 64'({1'b1, 1'b1, 8'h00, 1'b0}));
      check("stop_inh_done_edge", 64'(done_cyc), 64'(92));
      check("stop_inh_ready_low", 64'(rdy_d), 64'(1'b0));
      tx_data = 8'h5A; tx_valid = 1'b1; quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (!ps2_clk || !ps2_data || ready || done) quiet = 1'b0;
      end
      check("idle_inhibit_blocks_start", 64'(quiet), 64'(1'b1));
      tx_valid = 1'b0; inhibit = 1'b0;
      step();

      tx_data = 8'h1C; tx_valid = 1'b1;
      nf = 0;
      for (int i = 0; i < 80 && nf < 6; i++) begin
         step();
         if (i == 0) tx_valid = 1'b0;
         if (fell) nf++;
      end
      check("rst_sixth_fall", 64'({nf, ps2_clk}), 64'({32'sd6, 1'b0}));
      reset = 1'b0;
      #1;
      check("rst_lines_immediate", 64'({ps2_clk, ps2_data, done}), 64'(3'b110));
      step();
      step();
      reset = 1'b1;
      step();
      check("rst_ready_after_release", 64'(ready), 64'(1'b1));
      dn = 0; quiet = 1'b1;
      for (int i = 0; i < 120; i++) begin
         step();
         if (done) dn++;
         if (!ps2_clk || !ps2_data) quiet = 1'b0;
      end
      check("rst_no_done", 64'(dn), 64'(0));
      check("rst_lines_stay_high", 64'(quiet), 64'(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
